cache_mem_arbiter: RTL and testbench
====================================

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of cache instances sharing one memory port (range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data beat width.
REQ-003 SHALL have parameter MEM_ADDRESS_WIDTH, default 22, 2-byte-aligned memory address width.
REQ-004 SHALL run on one clock with a synchronous, active-low reset, named as the codebase names them:
- i_Clk  in  1  clock, all state updates on rising edge
- i_Reset_n  in  1  reset, synchronous, active-low
REQ-005 SHALL provide these requester-side ports:
- i_Req_Valid  in  NUM_PORTS  per-port memory request
- i_Req_Read_Write_n  in  NUM_PORTS  per-port direction, 1 = read
- i_Req_Address  in  NUM_PORTS*MEM_ADDRESS_WIDTH  packed addresses, port p at slice p
- i_Req_Data  in  NUM_PORTS*DATA_WIDTH  packed write data
- o_Req_Data_Read  out  NUM_PORTS  write beat consumed, granted port only
- o_Resp_Valid  out  NUM_PORTS  read beat valid, granted port only
- o_Resp_Last  out  NUM_PORTS  final beat, granted port only
- o_Resp_Data  out  DATA_WIDTH  shared read data, equal to i_MEM_Data
REQ-006 SHALL provide these memory-side ports:
- o_MEM_Valid  out  1
- o_MEM_Read_Write_n  out  1
- o_MEM_Address  out  MEM_ADDRESS_WIDTH
- o_MEM_Data  out  DATA_WIDTH
- i_MEM_Valid  in  1
- i_MEM_Data_Read  in  1
- i_MEM_Last  in  1
- i_MEM_Data  in  DATA_WIDTH
REQ-007 SHALL provide these status ports:
- o_Grant  out  NUM_PORTS  one-hot current owner, all zero when idle
- o_Busy  out  1  high in BUSY and DONE

Function
REQ-008 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-009 In IDLE with any i_Req_Valid bit high, SHALL latch a round-robin winner and enter BUSY on the next edge; o_MEM_Valid asserts exactly one cycle after the request is first seen.
REQ-010 Round-robin SHALL search from the port after the last-granted port, wrapping from NUM_PORTS-1 to 0.
REQ-011 In BUSY, o_MEM_Valid SHALL be 1. o_MEM_Read_Write_n, o_MEM_Address and o_MEM_Data SHALL combinationally follow the granted port's inputs.
REQ-012 In BUSY, i_MEM_Valid, i_MEM_Data_Read and i_MEM_Last SHALL route only to the granted port's o_Resp_Valid, o_Req_Data_Read and o_Resp_Last; all other ports see 0.
REQ-013 The burst end is i_MEM_Last together with (i_MEM_Valid or i_MEM_Data_Read) in BUSY. On that beat the FSM SHALL go to DONE and record the granted port as last-granted.
REQ-014 DONE SHALL last exactly one cycle with o_MEM_Valid=0 and o_Grant held, so the requester can drop its valid, then go to IDLE.
REQ-015 The grant SHALL stay locked until the burst end even if the granted i_Req_Valid falls mid-burst; new requests SHALL NOT preempt it.
REQ-016 Memory strobes in IDLE or DONE SHALL be ignored and not forwarded.
REQ-017 A port requesting continuously SHALL wait at most NUM_PORTS-1 bursts before it is granted.
REQ-018 Signals are not all registered: o_Grant and o_Busy are registered, all routed signals are combinational.

Reset
REQ-019 Reset SHALL force IDLE, o_Grant=0, o_Busy=0, o_MEM_Valid=0 and all per-port outputs to 0, and set last-granted to NUM_PORTS-1 so port 0 wins first.
REQ-020 Reset asserted mid-burst SHALL abandon the burst; no strobe reaches any port while i_Reset_n=0.

Structure
REQ-021 The FSM state enum and the grant-index width (the $clog2(NUM_PORTS) constant) SHALL live in the shared cache package.
REQ-022 The round-robin priority search SHALL be one sub-module, rr_pick, taking a request vector and last index and returning a one-hot winner plus its index.

Verification
REQ-023 Reset mid-burst: assert i_Reset_n=0 during a BUSY read -> next cycle IDLE, o_MEM_Valid=0, o_Grant=0.
REQ-024 Single read: port 0 requests read at address 0x00010 and memory returns 4 beats, Last on the 4th -> o_MEM_Valid at t+1, o_Resp_Valid[0] four times, o_Resp_Last[0] on the 4th, then a DONE cycle.
REQ-025 Simultaneous: ports 0 and 1 request at the same cycle after reset -> port 0 served first, then port 1 starts two cycles after port 0's last beat.
REQ-026 Fairness: NUM_PORTS=4, all ports request continuously for 8 bursts -> grant order 0,1,2,3,0,1,2,3.
REQ-027 Write burst: port 1 writes 4 beats, port 1 drops valid after beat 2 -> grant held, o_Req_Data_Read[1] pulses 4 times, other ports see 0.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache memory arbiter.
// Holds the arbiter FSM state type and the grant-index width helper.
package cache_mem_arbiter_pkg;

   localparam int MAX_PORTS = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_e;

   // Grant-index width, $clog2(NUM_PORTS), kept at least one bit wide.
   function automatic int grant_idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Round-robin priority search for the cache memory arbiter.
// Ports: i_Req request vector, i_Last last-granted index,
//        o_Onehot one-hot winner, o_Idx winner index.
module rr_pick
   import cache_mem_arbiter_pkg::*;
#(
   parameter  int NUM_PORTS = 2,
   localparam int IDX_W     = grant_idx_w(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] i_Req,
   input  logic [IDX_W-1:0]     i_Last,
   output logic [NUM_PORTS-1:0] o_Onehot,
   output logic [IDX_W-1:0]     o_Idx
);

   int w_Best_D;
   int w_Best_P;
   int w_D;

   // Distance from the port after i_Last, wrapping; smallest wins.
   always_comb begin
      w_Best_D = NUM_PORTS;
      w_Best_P = 0;
      w_D      = 0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_D = (p - int'(i_Last) - 1 + 2 * NUM_PORTS) % NUM_PORTS;
         if (i_Req[p] && (w_D < w_Best_D)) begin
            w_Best_D = w_D;
            w_Best_P = p;
         end
      end
   end

   always_comb begin
      o_Onehot = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         o_Onehot[p] = (p == w_Best_P) && (|i_Req);
      end
      o_Idx = IDX_W'(w_Best_P);
   end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates several cache instances onto one burst memory port.
// Ports: i_Clk/i_Reset_n clock and sync active-low reset;
//        i_Req_* / o_Req_Data_Read / o_Resp_* requester side;
//        o_MEM_* / i_MEM_* memory side; o_Grant / o_Busy status.
module cache_mem_arbiter
   import cache_mem_arbiter_pkg::*;
#(
   parameter int NUM_PORTS         = 2,
   parameter int DATA_WIDTH        = 32,
   parameter int MEM_ADDRESS_WIDTH = 22
) (
   input  logic                                   i_Clk,
   input  logic                                   i_Reset_n,
   input  logic [NUM_PORTS-1:0]                   i_Req_Valid,
   input  logic [NUM_PORTS-1:0]                   i_Req_Read_Write_n,
   input  logic [NUM_PORTS*MEM_ADDRESS_WIDTH-1:0] i_Req_Address,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]        i_Req_Data,
   output logic [NUM_PORTS-1:0]                   o_Req_Data_Read,
   output logic [NUM_PORTS-1:0]                   o_Resp_Valid,
   output logic [NUM_PORTS-1:0]                   o_Resp_Last,
   output logic [DATA_WIDTH-1:0]                  o_Resp_Data,
   output logic                                   o_MEM_Valid,
   output logic                                   o_MEM_Read_Write_n,
   output logic [MEM_ADDRESS_WIDTH-1:0]           o_MEM_Address,
   output logic [DATA_WIDTH-1:0]                  o_MEM_Data,
   input  logic                                   i_MEM_Valid,
   input  logic                                   i_MEM_Data_Read,
   input  logic                                   i_MEM_Last,
   input  logic [DATA_WIDTH-1:0]                  i_MEM_Data,
   output logic [NUM_PORTS-1:0]                   o_Grant,
   output logic                                   o_Busy
);

   localparam int IDX_W = grant_idx_w(NUM_PORTS);
   localparam int AW    = MEM_ADDRESS_WIDTH;
   localparam int DW    = DATA_WIDTH;

   arb_state_e             r_State;
   arb_state_e             w_Next;
   logic [NUM_PORTS-1:0]   r_Grant;
   logic [IDX_W-1:0]       r_Grant_Idx;
   logic [IDX_W-1:0]       r_Last_Idx;
   logic                   r_Busy;
   logic [NUM_PORTS-1:0]   w_Pick;
   logic [IDX_W-1:0]       w_Pick_Idx;
   logic                   w_Active;
   logic                   w_Burst_End;
   logic                   w_Rw;
   logic [AW-1:0]          w_Addr;
   logic [DW-1:0]          w_Data;

   rr_pick #(
      .NUM_PORTS(NUM_PORTS)
   ) u_rr_pick (
      .i_Req   (i_Req_Valid),
      .i_Last  (r_Last_Idx),
      .o_Onehot(w_Pick),
      .o_Idx   (w_Pick_Idx)
   );

   // Strobes are cut while reset is low so a burst dies immediately.
   assign w_Active    = (r_State == ST_BUSY) && i_Reset_n;
   assign w_Burst_End = w_Active && i_MEM_Last &&
                        (i_MEM_Valid || i_MEM_Data_Read);

   always_comb begin
      w_Next = r_State;
      case (r_State)
         ST_IDLE: if (|i_Req_Valid) w_Next = ST_BUSY;
         ST_BUSY: if (w_Burst_End) w_Next = ST_DONE;
         ST_DONE: w_Next = ST_IDLE;
         default: w_Next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         r_State <= ST_IDLE;
      end else begin
         r_State <= w_Next;
      end
   end

   // Grant is latched on entry to BUSY and held through DONE.
   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         r_Grant     <= '0;
         r_Grant_Idx <= '0;
         r_Last_Idx  <= IDX_W'(NUM_PORTS - 1);
         r_Busy      <= 1'b0;
      end else begin
         r_Busy <= (w_Next != ST_IDLE);
         if ((r_State == ST_IDLE) && (w_Next == ST_BUSY)) begin
            r_Grant     <= w_Pick;
            r_Grant_Idx <= w_Pick_Idx;
         end else if (w_Next == ST_IDLE) begin
            r_Grant <= '0;
         end
         if (w_Burst_End) begin
            r_Last_Idx <= r_Grant_Idx;
         end
      end
   end

   always_comb begin
      w_Rw   = 1'b0;
      w_Addr = '0;
      w_Data = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (r_Grant[p]) begin
            w_Rw   = i_Req_Read_Write_n[p];
            w_Addr = i_Req_Address[p*AW +: AW];
            w_Data = i_Req_Data[p*DW +: DW];
         end
      end
   end

   assign o_MEM_Valid        = w_Active;
   assign o_MEM_Read_Write_n = w_Rw;
   assign o_MEM_Address      = w_Addr;
   assign o_MEM_Data         = w_Data;
   assign o_Resp_Data        = i_MEM_Data;

   assign o_Resp_Valid    = r_Grant & {NUM_PORTS{w_Active & i_MEM_Valid}};
   assign o_Req_Data_Read = r_Grant & {NUM_PORTS{w_Active & i_MEM_Data_Read}};
   assign o_Resp_Last     = r_Grant & {NUM_PORTS{w_Active & i_MEM_Last}};

   assign o_Grant = r_Grant;
   assign o_Busy  = r_Busy;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter (4 ports).
// Directed vector table, fairness sequence, randomized model check.
module tb_cache_mem_arbiter;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int AW = 22;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NP-1:0]      req_v;
   logic [NP-1:0]      req_rw;
   logic [NP*AW-1:0]   req_addr;
   logic [NP*DW-1:0]   req_data;
   logic [NP-1:0]      o_rdr;
   logic [NP-1:0]      o_rv;
   logic [NP-1:0]      o_rl;
   logic [DW-1:0]      o_rdata;
   logic               o_mv;
   logic               o_mrw;
   logic [AW-1:0]      o_maddr;
   logic [DW-1:0]      o_mdata;
   logic               mv;
   logic               mdr;
   logic               ml;
   logic [DW-1:0]      mdata;
   logic [NP-1:0]      o_grant;
   logic               o_busy;

   logic [AW-1:0]      addr_a [NP];
   logic [DW-1:0]      data_a [NP];

   int n_tests = 0;
   int n_fail  = 0;

   cache_mem_arbiter #(
      .NUM_PORTS(NP),
      .DATA_WIDTH(DW),
      .MEM_ADDRESS_WIDTH(AW)
   ) dut (
      .i_Clk             (clk),
      .i_Reset_n         (rst_n),
      .i_Req_Valid       (req_v),
      .i_Req_Read_Write_n(req_rw),
      .i_Req_Address     (req_addr),
      .i_Req_Data        (req_data),
      .o_Req_Data_Read   (o_rdr),
      .o_Resp_Valid      (o_rv),
      .o_Resp_Last       (o_rl),
      .o_Resp_Data       (o_rdata),
      .o_MEM_Valid       (o_mv),
      .o_MEM_Read_Write_n(o_mrw),
      .o_MEM_Address     (o_maddr),
      .o_MEM_Data        (o_mdata),
      .i_MEM_Valid       (mv),
      .i_MEM_Data_Read   (mdr),
      .i_MEM_Last        (ml),
      .i_MEM_Data        (mdata),
      .o_Grant           (o_grant),
      .o_Busy            (o_busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_addr = '0;
      req_data = '0;
      for (int p = 0; p < NP; p++) begin
         req_addr[p*AW +: AW] = addr_a[p];
         req_data[p*DW +: DW] = data_a[p];
      end
   end

   typedef struct {
      bit         rst_n;
      logic [3:0] req;
      logic [3:0] rw;
      bit         mv;
      bit         mdr;
      bit         ml;
      bit         e_mv;
      logic [3:0] e_grant;
      bit         e_busy;
      logic [3:0] e_rv;
      logic [3:0] e_rdr;
      logic [3:0] e_rl;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(bit r, logic [3:0] rq, logic [3:0] rw,
                               bit v, bit d, bit l, bit emv,
                               logic [3:0] eg, bit eb, logic [3:0] erv,
                               logic [3:0] erdr, logic [3:0] erl);
      vec_t x;
      x.rst_n = r;   x.req = rq;    x.rw = rw;
      x.mv = v;      x.mdr = d;     x.ml = l;
      x.e_mv = emv;  x.e_grant = eg; x.e_busy = eb;
      x.e_rv = erv;  x.e_rdr = erdr; x.e_rl = erl;
      return x;
   endfunction

   function automatic int oh2i(logic [3:0] g);
      int r;
      r = 0;
      for (int p = 0; p < NP; p++) if (g[p]) r = p;
      return r;
   endfunction

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_v = '1;
      mv = 1'b1; mdr = 1'b1; ml = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_state",
          {o_grant, o_busy, o_mv, o_rv, o_rdr, o_rl},
          {4'b0, 1'b0, 1'b0, 4'b0, 4'b0, 4'b0});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_v = '0;
      mv = 1'b0; mdr = 1'b0; ml = 1'b0;
   endtask

   // Transaction-level reference: who owns the bus and whether the
   // post-burst release cycle is pending.
   int m_owner;
   bit m_done;
   int m_last;

   task automatic model_step();
      int c;
      if (!rst_n) begin
         m_owner = -1; m_done = 0; m_last = NP - 1;
      end else if (m_done) begin
         m_owner = -1; m_done = 0;
      end else if (m_owner >= 0) begin
         if (ml && (mv || mdr)) begin
            m_done = 1; m_last = m_owner;
         end
      end else if (req_v != 0) begin
         for (int k = 1; k <= NP; k++) begin
            c = (m_last + k) % NP;
            if (req_v[c] && m_owner < 0) m_owner = c;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] act;
      logic [127:0] exp;
      int           gi;
      int           w;
      bit           act_b;
      logic [3:0]   eg;

      for (int p = 0; p < NP; p++) begin
         addr_a[p] = 22'h00010 + AW'(p * 'h100);
         data_a[p] = 32'hD000_0000 + DW'(p);
      end
      req_rw = '0;
      mdata  = 32'h1234_5678;
      rst_n  = 1'b0;
      req_v  = '0;
      mv = 1'b0; mdr = 1'b0; ml = 1'b0;

      // single read, port 0, four beats
      vt.push_back(mk(1,4'b0001,4'b0001,0,0,0, 0,4'b0000,0,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0001,4'b0001,0,0,0, 1,4'b0001,1,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0001,4'b0001,1,0,0, 1,4'b0001,1,4'b0001,4'b0,4'b0));
      vt.push_back(mk(1,4'b0001,4'b0001,1,0,0, 1,4'b0001,1,4'b0001,4'b0,4'b0));
      vt.push_back(mk(1,4'b0001,4'b0001,1,0,0, 1,4'b0001,1,4'b0001,4'b0,4'b0));
      vt.push_back(mk(1,4'b0001,4'b0001,1,0,1, 1,4'b0001,1,4'b0001,4'b0,4'b0001));
      vt.push_back(mk(1,4'b0000,4'b0000,1,1,1, 0,4'b0001,1,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0000,4'b0000,1,0,1, 0,4'b0000,0,4'b0,4'b0,4'b0));
      // write burst, port 1 drops valid after beat 2, port 2 waits
      vt.push_back(mk(1,4'b0010,4'b0000,0,0,0, 0,4'b0000,0,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0010,4'b0000,0,1,0, 1,4'b0010,1,4'b0,4'b0010,4'b0));
      vt.push_back(mk(1,4'b0010,4'b0000,0,1,0, 1,4'b0010,1,4'b0,4'b0010,4'b0));
      vt.push_back(mk(1,4'b0100,4'b0000,0,1,0, 1,4'b0010,1,4'b0,4'b0010,4'b0));
      vt.push_back(mk(1,4'b0100,4'b0000,0,1,1, 1,4'b0010,1,4'b0,4'b0010,4'b0010));
      vt.push_back(mk(1,4'b0100,4'b0000,0,0,0, 0,4'b0010,1,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0100,4'b0100,0,0,0, 0,4'b0000,0,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0100,4'b0100,1,0,0, 1,4'b0100,1,4'b0100,4'b0,4'b0));
      // reset in the middle of port 2's read
      vt.push_back(mk(0,4'b0100,4'b0100,1,1,1, 0,4'b0100,1,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0000,4'b0000,1,0,0, 0,4'b0000,0,4'b0,4'b0,4'b0));
      // ports 0 and 1 together; port 1 seen in IDLE two cycles after
      // port 0's last beat and on the bus the cycle after
      vt.push_back(mk(1,4'b0011,4'b0011,0,0,0, 0,4'b0000,0,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0011,4'b0011,1,0,1, 1,4'b0001,1,4'b0001,4'b0,4'b0001));
      vt.push_back(mk(1,4'b0010,4'b0011,0,0,0, 0,4'b0001,1,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0010,4'b0011,0,0,0, 0,4'b0000,0,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0010,4'b0011,0,0,0, 1,4'b0010,1,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0000,4'b0011,1,0,1, 1,4'b0010,1,4'b0010,4'b0,4'b0010));
      vt.push_back(mk(1,4'b0000,4'b0011,0,0,0, 0,4'b0010,1,4'b0,4'b0,4'b0));
      vt.push_back(mk(1,4'b0000,4'b0011,0,0,0, 0,4'b0000,0,4'b0,4'b0,4'b0));

      do_reset();

      foreach (vt[i]) begin
         rst_n  = vt[i].rst_n;
         req_v  = vt[i].req;
         req_rw = vt[i].rw;
         mv  = vt[i].mv;
         mdr = vt[i].mdr;
         ml  = vt[i].ml;
         @(negedge clk);
         gi = oh2i(vt[i].e_grant);
         act = '0;
         exp = '0;
         act = {o_mv, o_grant, o_busy, o_rv, o_rdr, o_rl,
                o_mv ? o_mrw : 1'b0,
                o_mv ? o_maddr : {AW{1'b0}},
                o_mv ? o_mdata : {DW{1'b0}}};
         exp = {vt[i].e_mv, vt[i].e_grant, vt[i].e_busy,
                vt[i].e_rv, vt[i].e_rdr, vt[i].e_rl,
                vt[i].e_mv ? vt[i].rw[gi] : 1'b0,
                vt[i].e_mv ? addr_a[gi] : {AW{1'b0}},
                vt[i].e_mv ? data_a[gi] : {DW{1'b0}}};
         chk($sformatf("vec%0d", i), act, exp);
         @(posedge clk);
         #1;
      end

      // fairness: all four ports request continuously
      do_reset();
      req_v  = 4'b1111;
      req_rw = 4'b1111;
      for (int b = 0; b < 8; b++) begin
         w = 0;
         @(negedge clk);
         while (!o_mv && w < 10) begin
            @(negedge clk);
            w++;
         end
         if (!o_mv) begin
            n_tests++;
            n_fail++;
            $display("FAIL fair_wait%0d: got no o_MEM_Valid expected grant", b);
         end
         chk($sformatf("fair%0d", b), 128'(o_grant), 128'(4'b0001 << (b % 4)));
         mv = 1'b1;
         ml = 1'b1;
         @(posedge clk);
         #1;
         mv = 1'b0;
         ml = 1'b0;
      end

      // randomized run against the transaction model
      do_reset();
      m_owner = -1;
      m_done  = 0;
      m_last  = NP - 1;
      for (int c = 0; c < 3000; c++) begin
         rst_n  = ($urandom_range(0, 199) != 0);
         req_v  = 4'($urandom);
         req_rw = 4'($urandom);
         mv     = ($urandom_range(0, 1) == 1);
         mdr    = ($urandom_range(0, 1) == 1);
         ml     = ($urandom_range(0, 3) == 0);
         mdata  = $urandom;
         for (int p = 0; p < NP; p++) begin
            addr_a[p] = AW'($urandom);
            data_a[p] = $urandom;
         end
         @(negedge clk);
         act_b = (m_owner >= 0) && !m_done && rst_n;
         eg    = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         gi    = (m_owner >= 0) ? m_owner : 0;
         act = '0;
         exp = '0;
         act = {o_mv, o_grant, o_busy, o_rv, o_rdr, o_rl,
                o_mrw, o_maddr, o_mdata, o_rdata};
         exp = {act_b, eg, (m_owner >= 0),
                (act_b && mv) ? eg : 4'b0,
                (act_b && mdr) ? eg : 4'b0,
                (act_b && ml) ? eg : 4'b0,
                (m_owner >= 0) ? req_rw[gi] : 1'b0,
                (m_owner >= 0) ? addr_a[gi] : {AW{1'b0}},
                (m_owner >= 0) ? data_a[gi] : {DW{1'b0}},
                mdata};
         chk($sformatf("rand%0d", c), act, exp);
         model_step();
         @(posedge clk);
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
